// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants and helpers for the 7-segment scanner:
//   SEG_LUT   - 16-entry active-low segment patterns, bits [6:0] = g..a
//   SEG_BLANK - cathode value for a dark digit (all segments and DP off)
//   idx_width - width of the digit index register, never less than 1
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Entry n is the pattern for hex digit n (entry 15 is leftmost).
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Combinational nibble-to-cathode decoder for one display slot.
// Ports:
//   i_nibble  - hex digit to show
//   i_dp      - decimal point, 1 = lit
//   i_blank   - 1 forces the whole digit dark
//   o_cathode - active-low segments, [7] = DP, [6:0] = g..a
// ---------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    input  logic       i_blank,
    output logic [7:0] o_cathode
);

    always_comb begin
        o_cathode = SEG_BLANK;
        if (!i_blank) begin
            o_cathode = {~i_dp, SEG_LUT[i_nibble]};
        end
    end

endmodule

// File: rtl/seg7_scan_top.sv
// ---------------------------------------------------------------------------
// seg7_scan_top
// Time-multiplexed multi-digit 7-segment scanner with a double-buffered
// display value. New data is staged on i_load and committed to the shadow
// buffer only at the start of a frame, so a frame never mixes old and new.
// Ports:
//   i_clk, i_reset  - clock, synchronous active-high reset
//   i_load          - capture i_value/i_dp/i_digit_en into the stage buffer
//   i_value         - hex nibbles, digit i = i_value[4i+3:4i]
//   i_dp            - per-digit decimal point, 1 = lit
//   i_digit_en      - per-digit enable, 0 = blanked
//   o_anode         - active-low one-hot digit select
//   o_cathode       - active-low segments, [7] = DP
//   o_frame_start   - one-cycle pulse as digit 0's slot begins
//   o_pending       - staged data not yet committed
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
// ---------------------------------------------------------------------------
module seg7_scan_top
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_digit_en,
    output logic [NUM_DIGITS-1:0]   o_anode,
    output logic [7:0]              o_cathode,
    output logic                    o_frame_start,
    output logic                    o_pending
);

    localparam int unsigned IW = idx_width(NUM_DIGITS);
    localparam int unsigned PW = (REFRESH_DIV <= 1) ? 1 : $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           r_presc;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_stage_val;
    logic [NUM_DIGITS-1:0]   r_stage_dp;
    logic [NUM_DIGITS-1:0]   r_stage_en;
    logic [4*NUM_DIGITS-1:0] r_shadow_val;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [NUM_DIGITS-1:0]   r_shadow_en;
    logic                    r_pending;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [7:0]              r_cathode;
    logic                    r_frame_start;

    logic                    w_tick;
    logic                    w_commit;
    logic [4*NUM_DIGITS-1:0] w_val;
    logic [NUM_DIGITS-1:0]   w_dp;
    logic [NUM_DIGITS-1:0]   w_en;
    logic [3:0]              w_nib;
    logic                    w_dp_sel;
    logic                    w_en_sel;
    logic                    w_blank;
    logic [7:0]              w_cathode;
    logic [NUM_DIGITS-1:0]   w_anode;

    assign w_tick   = (r_presc == PRESC_LAST);
    assign w_commit = w_tick && (r_idx == '0) && r_pending;

    // The digit-0 slot that commits displays the freshly committed data, so
    // bypass the shadow with the stage contents on that one edge.
    assign w_val = w_commit ? r_stage_val : r_shadow_val;
    assign w_dp  = w_commit ? r_stage_dp  : r_shadow_dp;
    assign w_en  = w_commit ? r_stage_en  : r_shadow_en;

    assign w_nib    = w_val[{r_idx, 2'b00} +: 4];
    assign w_dp_sel = w_dp[r_idx];
    assign w_en_sel = w_en[r_idx];

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] w_suppress;

    // Walk from the top digit down; the run of zeros ends at the first
    // enabled digit that is non-zero or has its DP lit. Digit 0 never blanks.
    always_comb begin
        logic v_zero_run;
        w_suppress = '0;
        v_zero_run = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
            if (w_en[i]) begin
                v_zero_run = v_zero_run && (w_val[4*i +: 4] == 4'h0) && !w_dp[i];
            end
            w_suppress[i] = v_zero_run;
        end
    end

    assign w_blank = !w_en_sel || w_suppress[r_idx];
`else
    assign w_blank = !w_en_sel;
`endif

    seg7_decode u_decode (
        .i_nibble  (w_nib),
        .i_dp      (w_dp_sel),
        .i_blank   (w_blank),
        .o_cathode (w_cathode)
    );

    always_comb begin
        w_anode = '1;
        if (!w_blank) begin
            w_anode = ~(NUM_DIGITS'(1) << r_idx);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_presc       <= '0;
            r_idx         <= '0;
            r_stage_val   <= '0;
            r_stage_dp    <= '0;
            r_stage_en    <= '0;
            r_shadow_val  <= '0;
            r_shadow_dp   <= '0;
            r_shadow_en   <= '0;
            r_pending     <= 1'b0;
            r_anode       <= '1;
            r_cathode     <= SEG_BLANK;
            r_frame_start <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;

            if (i_load) begin
                r_stage_val <= i_value;
                r_stage_dp  <= i_dp;
                r_stage_en  <= i_digit_en;
            end

            // A load coinciding with a commit keeps pending set for next frame.
            if (i_load) begin
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end

            if (w_commit) begin
                r_shadow_val <= r_stage_val;
                r_shadow_dp  <= r_stage_dp;
                r_shadow_en  <= r_stage_en;
            end

            r_frame_start <= w_tick && (r_idx == '0);

            if (w_tick) begin
                r_anode   <= w_anode;
                r_cathode <= w_cathode;
                r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign o_anode       = r_anode;
    assign o_cathode     = r_cathode;
    assign o_frame_start = r_frame_start;
    assign o_pending     = r_pending;

endmodule

// File: tb/tb_seg7_scan_top.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_top
// Directed bench for seg7_scan_top: a 4-digit / divide-by-4 instance for the
// scanning and double-buffer behaviour, and a 1-digit / divide-by-1 instance
// for the degenerate corner. Inputs change and outputs are sampled 1 time
// unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_seg7_scan_top;

    logic        clk;
    logic        rst, load;
    logic [15:0] value;
    logic [3:0]  dp, en;
    logic [3:0]  anode;
    logic [7:0]  cathode;
    logic        fs, pend;

    logic        rst2, load2;
    logic [3:0]  value2;
    logic        dp2, en2;
    logic        anode2;
    logic [7:0]  cathode2;
    logic        fs2, pend2;

    int total = 0;
    int bad   = 0;

    seg7_scan_top #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4)
    ) u_dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_load        (load),
        .i_value       (value),
        .i_dp          (dp),
        .i_digit_en    (en),
        .o_anode       (anode),
        .o_cathode     (cathode),
        .o_frame_start (fs),
        .o_pending     (pend)
    );

    seg7_scan_top #(
        .NUM_DIGITS  (1),
        .REFRESH_DIV (1)
    ) u_dut1 (
        .i_clk         (clk),
        .i_reset       (rst2),
        .i_load        (load2),
        .i_value       (value2),
        .i_dp          (dp2),
        .i_digit_en    (en2),
        .o_anode       (anode2),
        .o_cathode     (cathode2),
        .o_frame_start (fs2),
        .o_pending     (pend2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after the tick edge that displayed digit 0; returns at the
    // same point of the following frame.
    task automatic check_frame(input string tag, input logic [15:0] exp_an,
                               input logic [31:0] exp_ca);
        for (int s = 0; s < 4; s++) begin
            check_eq({tag, "_an"}, 32'(anode), 32'(exp_an[4*s +: 4]));
            check_eq({tag, "_ca"}, 32'(cathode), 32'(exp_ca[8*s +: 8]));
            check_eq({tag, "_fs"}, 32'(fs), (s == 0) ? 32'd1 : 32'd0);
            repeat (3) step();
            check_eq({tag, "_an_hold"}, 32'(anode), 32'(exp_an[4*s +: 4]));
            check_eq({tag, "_ca_hold"}, 32'(cathode), 32'(exp_ca[8*s +: 8]));
            check_eq({tag, "_fs_low"}, 32'(fs), 32'd0);
            step();
        end
    endtask

    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        while (fs !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check_eq({tag, "_fs_timeout"}, 32'(fs), 32'd1);
    endtask

    // Load from mid-frame (slot 1) and check the new frame after commit.
    task automatic load_and_frame(input string tag, input logic [15:0] v, input logic [3:0] d,
                                  input logic [3:0] e, input logic [15:0] exp_an,
                                  input logic [31:0] exp_ca);
        repeat (4) step();
        value = v;
        dp    = d;
        en    = e;
        load  = 1'b1;
        step();
        load  = 1'b0;
        check_eq({tag, "_pend_set"}, 32'(pend), 32'd1);
        wait_fs(tag);
        check_eq({tag, "_pend_clr"}, 32'(pend), 32'd0);
        check_frame(tag, exp_an, exp_ca);
    endtask

    initial begin
        int first;
        int nonblank;

        rst = 1'b1; load = 1'b0; value = '0; dp = '0; en = '0;
        rst2 = 1'b1; load2 = 1'b0; value2 = '0; dp2 = 1'b0; en2 = 1'b0;
        step();
        step();
        check_eq("rst_anode", 32'(anode), 32'hF);
        check_eq("rst_cathode", 32'(cathode), 32'hFF);
        check_eq("rst_fs", 32'(fs), 32'd0);
        check_eq("rst_pend", 32'(pend), 32'd0);
        rst = 1'b0;

        // No load: blank for 40 cycles, first frame_start after edge 4.
        first = 0;
        nonblank = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (fs === 1'b1 && first == 0) first = c;
            if (anode !== 4'hF || cathode !== 8'hFF) nonblank++;
        end
        check_eq("idle_blank", 32'(nonblank), 32'd0);
        check_eq("first_fs_cycle", 32'(first), 32'd4);

        // 12AF with DP on digit 2.
        value = 16'h12AF; dp = 4'b0100; en = 4'hF; load = 1'b1;
        step();
        load = 1'b0;
        check_eq("f1_pend_set", 32'(pend), 32'd1);
        wait_fs("f1");
        check_eq("f1_pend_clr", 32'(pend), 32'd0);
        check_frame("f1", 16'h7BDE, 32'hF924888E);

        // Load at idx 2: old digits 2 and 3 keep showing this frame.
        repeat (8) step();
        value = 16'h3456; dp = 4'b0000; en = 4'hF; load = 1'b1;
        step();
        load = 1'b0;
        check_eq("mid_an2", 32'(anode), 32'hB);
        check_eq("mid_ca2", 32'(cathode), 32'h24);
        check_eq("mid_pend2", 32'(pend), 32'd1);
        repeat (3) step();
        check_eq("mid_an3", 32'(anode), 32'h7);
        check_eq("mid_ca3", 32'(cathode), 32'hF9);
        check_eq("mid_pend3", 32'(pend), 32'd1);
        repeat (4) step();
        check_eq("mid_fs", 32'(fs), 32'd1);
        check_eq("mid_pend_clr", 32'(pend), 32'd0);
        check_frame("f2", 16'h7BDE, 32'hB0999282);

        // Stage A, then load B on the very edge that commits A.
        repeat (4) step();
        value = 16'h1C0D; dp = 4'b0000; en = 4'hF; load = 1'b1;
        step();
        load = 1'b0;
        check_eq("sim_pend_a", 32'(pend), 32'd1);
        repeat (10) step();
        value = 16'h9876; dp = 4'b0001; en = 4'hF; load = 1'b1;
        step();
        load = 1'b0;
        check_eq("sim_fs", 32'(fs), 32'd1);
        check_eq("sim_pend_keep", 32'(pend), 32'd1);
        check_frame("sim_a", 16'h7BDE, 32'hF9C6C0A1);
        check_eq("sim_pend_clr", 32'(pend), 32'd0);
        check_frame("sim_b", 16'h7BDE, 32'h9080F802);

        // Digits 0 and 2 disabled.
        load_and_frame("en1010", 16'h4321, 4'b0000, 4'b1010, 16'h7FDF, 32'h99FFA4FF);

`ifdef LEADING_ZERO_BLANK_EN
        load_and_frame("lzb", 16'h0050, 4'b0000, 4'hF, 16'hFFDE, 32'hFFFF92C0);
`else
        load_and_frame("zeros", 16'h0050, 4'b0000, 4'hF, 16'h7BDE, 32'hC0C092C0);
`endif
        load_and_frame("zeros_dp3", 16'h0050, 4'b1000, 4'hF, 16'h7BDE, 32'h40C092C0);

        // Reset mid-slot with a load in flight.
        repeat (2) step();
        value = 16'hFFFF; dp = 4'hF; en = 4'hF; load = 1'b1; rst = 1'b1;
        step();
        load = 1'b0;
        check_eq("mrst_anode", 32'(anode), 32'hF);
        check_eq("mrst_cathode", 32'(cathode), 32'hFF);
        check_eq("mrst_fs", 32'(fs), 32'd0);
        check_eq("mrst_pend", 32'(pend), 32'd0);
        rst = 1'b0;
        first = 0;
        nonblank = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (fs === 1'b1 && first == 0) first = c;
            if (anode !== 4'hF || cathode !== 8'hFF) nonblank++;
        end
        check_eq("mrst_blank", 32'(nonblank), 32'd0);
        check_eq("mrst_first_fs", 32'(first), 32'd4);

        // Single digit, tick every cycle.
        check_eq("d1_rst_anode", 32'(anode2), 32'd1);
        check_eq("d1_rst_cathode", 32'(cathode2), 32'hFF);
        rst2 = 1'b0;
        value2 = 4'h7; en2 = 1'b1; load2 = 1'b1;
        step();
        load2 = 1'b0;
        check_eq("d1_first_fs", 32'(fs2), 32'd1);
        check_eq("d1_first_blank", 32'(anode2), 32'd1);
        check_eq("d1_pend", 32'(pend2), 32'd1);
        for (int c = 0; c < 5; c++) begin
            step();
            check_eq("d1_anode", 32'(anode2), 32'd0);
            check_eq("d1_cathode", 32'(cathode2), 32'hF8);
            check_eq("d1_fs", 32'(fs2), 32'd1);
            check_eq("d1_pend_clr", 32'(pend2), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_top.md
Name: seg7_scan_top

Overview:
- Parametrised multi-digit 7-segment scanner. Drives one shared active-low cathode bus and NUM_DIGITS active-low anodes, time-multiplexing one digit per refresh slot.
- Displays a double-buffered hex value with a per-digit decimal point and enable, so a frame never mixes old and new data.
- Sits between the value-producing logic and the board display pins.

Parameters:
- NUM_DIGITS, 8, digits scanned; legal 1..16.
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz/digit at 100 MHz); legal >= 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  capture value/dp/digit_en into the stage buffer.
- value  in  4*NUM_DIGITS  hex nibbles; digit i = value[4i+3:4i]; digit 0 is least significant and rightmost.
- dp  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- digit_en  in  NUM_DIGITS  1 = digit shown, 0 = blanked.
- anode  out  NUM_DIGITS  active-low digit select, one-hot-low.
- cathode  out  8  active-low segments; [6:0] = g..a, [7] = DP.
- frame_start  out  1  one-cycle pulse when digit 0's slot begins.
- pending  out  1  staged data not yet committed.

Behaviour:
- Reset: prescaler=0, idx=0, stage and shadow buffers cleared (value 0, dp 0, en 0), pending=0, anode all 1, cathode 8'hFF, frame_start=0.
- tick = (prescaler == REFRESH_DIV-1). On tick the prescaler returns to 0; otherwise it increments. REFRESH_DIV=1 gives a tick every cycle.
- anode and cathode are registered and update only on a tick edge, so both are held constant for REFRESH_DIV cycles per slot.
- On tick, the slot shown is the current idx. Then idx advances, wrapping NUM_DIGITS-1 to 0. With NUM_DIGITS=1, idx stays 0.
- The first tick after reset (cycle REFRESH_DIV) shows digit 0.
- anode for a shown slot: bit idx = 0, all others 1.
- If the slot's digit is blanked (digit_en=0, or suppressed by the optional feature): anode all 1, cathode 8'hFF.
- Segment patterns, active-low, bits [6:0]:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- cathode[7] = ~dp[idx].
- Latency: segment data for slot k is decoded from the shadow buffer and registered on the same tick edge as anode; zero skew between anode and cathode.
- Double buffering:
  - load=1 at edge: stage <= {value, dp, digit_en}; pending <= 1.
  - On a tick with idx==0 and pending=1: shadow <= stage, pending <= 0. The committed data is used for that digit-0 slot.
- Simultaneous load and commit in the same cycle: the commit uses the pre-edge stage contents; the new load is captured and pending remains 1, so it commits next frame.
- Repeated loads before a commit: the last load wins.
- frame_start = 1 for exactly the cycle following a tick edge that displayed idx 0; it is registered alongside anode.
- Reset asserted mid-slot or mid-frame: all state returns to reset values on that edge; outputs blank until the first tick after deassertion.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: a digit i > 0 is suppressed when it and every higher enabled digit have value 0 and dp 0.
  - Digit 0 is never suppressed.
  - A digit with dp=1 is shown and stops suppression below it.
  - Suppression is computed from the shadow buffer.
- Undefined: only digit_en blanks digits; zeros display as "0".

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry active-low segment pattern constant;
  - SEG_BLANK = 8'hFF;
  - a function for idx width (max(1, clog2(NUM_DIGITS))).
- One sub-module, seg7_decode: combinational nibble + dp + blank -> 8-bit cathode. Reused per slot; registration stays in the top.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4 unless noted):
- Reset, no load: anode=4'hF and cathode=8'hFF for 40 cycles; first frame_start at cycle 4.
- load value=16'h12AF, dp=4'b0100, en=4'hF: after the next idx-0 tick, the slot sequence is:
  - anode E, cathode 8E
  - anode D, cathode 88
  - anode B, cathode 24 (DP lit)
  - anode 7, cathode F9
  - Each slot is held 4 cycles.
- Load mid-frame at idx 2: the old digits 2 and 3 still show; the new value appears starting at the next digit-0 slot. pending=1 until the commit, then 0.
- load in the same cycle as an idx-0 commit tick: the old stage is displayed this frame, the new value next frame, and pending stays 1 across the boundary.
- en=4'b1010: slots 0 and 2 show anode F, cathode FF; slots 1 and 3 are shown normally.
- With LEADING_ZERO_BLANK_EN, value=16'h0050, dp=0: digits 3 and 2 are blanked, digits 1 and 0 show "5" (12) and "0" (40). With dp[3]=1, digit 3 shows C0.
- REFRESH_DIV=1, NUM_DIGITS=1: anode=0 every cycle after the first tick, and frame_start is high every cycle.
